rsa_decrypt_ctrl: RTL and testbench

//  Sequencer for RSA decryption m = c^d mod n over the stored modulus/key/cipher registers.

---
 rtl/rsa_decrypt_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rsa_decrypt_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_decrypt_ctrl.sv
// Square-and-multiply sequencer for m = c^d mod n; WIDTH+popcount(d) multiplier requests, one req/ack in flight, start ignored while busy.
// Optional RSA_CTRL_LZ_SKIP_EN: start the scan at the MSB set bit of d and skip its leading squaring.
module rsa_decrypt_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] m_out,
  output logic             mm_req,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic             mm_ack,
  input  logic [WIDTH-1:0] mm_result
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, INIT, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, FIN
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] n_q, d_q, c_q, acc_q;
  logic [IW-1:0]    i_q;
  logic             busy_q, done_q, err_q, mm_req_q;
  logic [WIDTH-1:0] m_q, mm_a_q, mm_b_q, mm_n_q;
  logic [WIDTH-1:0] acc_init;

  // Anything mod 1 is 0, so the accumulator starts at 0 for n==1.
  assign acc_init = {{(WIDTH-1){1'b0}}, (n_q != WIDTH'(1))};

`ifdef RSA_CTRL_LZ_SKIP_EN
  function automatic logic [IW-1:0] msb_idx(input logic [WIDTH-1:0] v);
    msb_idx = '0;
    for (int k = 0; k < WIDTH; k++)
      if (v[k]) msb_idx = IW'(k);
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      d_q      <= '0;
      c_q      <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      m_q      <= '0;
      mm_req_q <= 1'b0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
      mm_n_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q     <= n_in;
            d_q     <= d_in;
            c_q     <= c_in;
            mm_n_q  <= n_in;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= INIT;
          end
        end
        INIT: begin
          if (n_q == '0) begin
            err_q   <= 1'b1;
            m_q     <= '0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
`ifdef RSA_CTRL_LZ_SKIP_EN
          else if (d_q == '0) begin
            m_q     <= acc_init;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            // Squaring the initial accumulator is a no-op, so the MSB goes straight to multiply.
            acc_q   <= acc_init;
            i_q     <= msb_idx(d_q);
            state_q <= MUL_REQ;
          end
`else
          else begin
            acc_q   <= acc_init;
            i_q     <= IW'(WIDTH-1);
            state_q <= SQR_REQ;
          end
`endif
        end
        SQR_REQ: begin
          mm_req_q <= 1'b1;
          mm_a_q   <= acc_q;
          mm_b_q   <= acc_q;
          state_q  <= SQR_WAIT;
        end
        SQR_WAIT: begin
          if (mm_ack) begin
            mm_req_q <= 1'b0;
            acc_q    <= mm_result;
            if (d_q[i_q]) begin
              state_q <= MUL_REQ;
            end else if (i_q == '0) begin
              m_q     <= mm_result;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              i_q     <= i_q - IW'(1);
              state_q <= SQR_REQ;
            end
          end
        end
        MUL_REQ: begin
          mm_req_q <= 1'b1;
          mm_a_q   <= acc_q;
          mm_b_q   <= c_q;
          state_q  <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mm_ack) begin
            mm_req_q <= 1'b0;
            acc_q    <= mm_result;
            if (i_q == '0) begin
              m_q     <= mm_result;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              i_q     <= i_q - IW'(1);
              state_q <= SQR_REQ;
            end
          end
        end
        FIN: begin
          // done was raised on entry, so it and busy overlap for this single cycle.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign m_out  = m_q;
  assign mm_req = mm_req_q;
  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
  assign mm_n   = mm_n_q;

endmodule

// File: tb/tb_rsa_decrypt_ctrl.sv
// Directed and random checks of rsa_decrypt_ctrl against a behavioural modular multiplier
// and a right-to-left modular exponentiation reference.
module tb_rsa_decrypt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] n_in, d_in, c_in;
  logic        busy, done, err;
  logic [31:0] m_out;
  logic        mm_req;
  logic [31:0] mm_a, mm_b, mm_n;
  logic        mm_ack;
  logic [31:0] mm_result;

  rsa_decrypt_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .n_in(n_in), .d_in(d_in), .c_in(c_in),
    .busy(busy), .done(done), .err(err), .m_out(m_out),
    .mm_req(mm_req), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_ack(mm_ack), .mm_result(mm_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modexp(input logic [31:0] n, input logic [31:0] d, input logic [31:0] c);
    longint unsigned r, b, nn;
    logic [31:0] e;
    nn = 64'(n);
    r  = 64'd1 % nn;
    b  = 64'(c) % nn;
    e  = d;
    while (e != 0) begin
      if (e[0]) r = (r * b) % nn;
      b = (b * b) % nn;
      e = e >> 1;
    end
    return r[31:0];
  endfunction

  // Behavioural multiplier: ack one cycle after req rises plus an extra delay.
  int          dly_mode = 0;   // 0: no extra delay, 1: random 0..7, 2: fixed 7
  bit          spur_en  = 1'b0;
  int          req_cnt  = 0;
  int          unstable = 0;
  int          cnt      = 0;
  bit          acked    = 1'b0;
  bit          req_prev = 1'b0;
  logic [31:0] a0, b0, n0;

  always @(negedge clk) begin
    mm_ack    = 1'b0;
    mm_result = 32'h0;
    if (mm_req) begin
      if (!req_prev) begin
        req_cnt++;
        a0 = mm_a; b0 = mm_b; n0 = mm_n;
        acked = 1'b0;
        cnt = (dly_mode == 1) ? int'($urandom_range(0, 7)) : (dly_mode == 2) ? 7 : 0;
      end else if (mm_a !== a0 || mm_b !== b0 || mm_n !== n0) begin
        unstable++;
      end
      if (!acked) begin
        if (cnt == 0) begin
          mm_ack    = 1'b1;
          mm_result = 32'((64'(mm_a) * 64'(mm_b)) % 64'(mm_n));
          acked     = 1'b1;
        end else begin
          cnt--;
        end
      end
    end else if (spur_en && busy) begin
      mm_ack    = 1'b1;
      mm_result = 32'hDEAD_BEEF;
    end
    req_prev = mm_req;
  end

  logic [31:0] m_obs;
  logic        e_obs;
  int          done_cnt;
  logic        busy_start, busy_at_done, busy_after;

  task automatic run_op(input logic [31:0] n, input logic [31:0] d, input logic [31:0] c, input bit disturb);
    int cyc;
    bit seen;
    @(negedge clk);
    n_in = n; d_in = d; c_in = c; start = 1'b1;
    req_cnt = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    n_in = 32'h0; d_in = 32'hFFFF_FFFF; c_in = 32'h1234_5678;
    busy_start = busy;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 3000) begin
      start = (disturb && (cyc == 3 || cyc == 4 || cyc == 40)) ? 1'b1 : 1'b0;
      if (done) begin
        seen = 1'b1;
        done_cnt++;
        busy_at_done = busy;
        m_obs = m_out;
        e_obs = err;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 64'(cyc), 64'(0));
      m_obs = 32'hX; e_obs = 1'bX;
    end
    busy_after = busy;
    for (int k = 0; k < 4; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rn, rd, rc;
    int rq_bad;
    rst = 1'b1; start = 1'b0;
    n_in = '0; d_in = '0; c_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   64'(busy),   64'(0));
    check("rst_done",   64'(done),   64'(0));
    check("rst_err",    64'(err),    64'(0));
    check("rst_mm_req", 64'(mm_req), 64'(0));
    check("rst_m_out",  64'(m_out),  64'(0));
    check("rst_mm_n",   64'(mm_n),   64'(0));
    rst = 1'b0;

    // Base case: 29^7 mod 33 = 17
    run_op(32'd33, 32'd7, 32'd29, 1'b0);
    check("base_m",        64'(m_obs),        64'(17));
    check("base_err",      64'(e_obs),        64'(0));
    check("base_dones",    64'(done_cnt),     64'(1));
    check("base_busy_st",  64'(busy_start),   64'(1));
    check("base_busy_dn",  64'(busy_at_done), 64'(1));
    check("base_busy_aft", 64'(busy_after),   64'(0));
`ifdef RSA_CTRL_LZ_SKIP_EN
    check("base_reqs",     64'(req_cnt),      64'(5));
`else
    check("base_reqs",     64'(req_cnt),      64'(35));
`endif

    // d = 0
    run_op(32'd33, 32'd0, 32'd5, 1'b0);
    check("d0_m", 64'(m_obs), 64'(1));
`ifdef RSA_CTRL_LZ_SKIP_EN
    check("d0_reqs", 64'(req_cnt), 64'(0));
`else
    check("d0_reqs", 64'(req_cnt), 64'(32));
`endif

    // n = 0 flags err, then a good run clears it
    run_op(32'd0, 32'd7, 32'd29, 1'b0);
    check("n0_err",   64'(e_obs),    64'(1));
    check("n0_m",     64'(m_obs),    64'(0));
    check("n0_reqs",  64'(req_cnt),  64'(0));
    check("n0_dones", 64'(done_cnt), 64'(1));
    run_op(32'd33, 32'd7, 32'd29, 1'b0);
    check("n0_clr_err", 64'(e_obs), 64'(0));
    check("n0_clr_m",   64'(m_obs), 64'(17));

    // start while busy and spurious acks outside the wait states
    spur_en = 1'b1;
    run_op(32'd33, 32'd7, 32'd29, 1'b1);
    spur_en = 1'b0;
    check("dist_m",     64'(m_obs),    64'(17));
    check("dist_dones", 64'(done_cnt), 64'(1));

    // random operands with random ack delay
    dly_mode = 1;
    unstable = 0;
    rq_bad   = 0;
    for (int r = 0; r < 120; r++) begin
      rn = $urandom; if (rn < 2) rn = 2;
      rd = $urandom;
      rc = $urandom;
      if (r == 0) begin rn = 32'hFFFF_FFFB; rd = 32'hFFFF_FFFF; rc = 32'hFFFF_FFFF; end
      run_op(rn, rd, rc, 1'b0);
      check("rand_m", 64'(m_obs), 64'(modexp(rn, rd, rc)));
`ifndef RSA_CTRL_LZ_SKIP_EN
      if (req_cnt != 32 + $countones(rd)) rq_bad++;
`endif
    end
    check("rand_stable", 64'(unstable), 64'(0));
    check("rand_reqs",   64'(rq_bad),   64'(0));

    // reset while a squaring is outstanding
    dly_mode = 2;
    @(negedge clk);
    n_in = 32'd33; d_in = 32'd7; c_in = 32'd29; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !mm_req; k++) @(negedge clk);
    check("mid_req_seen", 64'(mm_req), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_busy",   64'(busy),   64'(0));
    check("mid_done",   64'(done),   64'(0));
    check("mid_err",    64'(err),    64'(0));
    check("mid_mm_req", 64'(mm_req), 64'(0));
    check("mid_m_out",  64'(m_out),  64'(0));
    check("mid_mm_a",   64'(mm_a),   64'(0));
    check("mid_mm_b",   64'(mm_b),   64'(0));
    check("mid_mm_n",   64'(mm_n),   64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dly_mode = 0;
    run_op(32'd33, 32'd7, 32'd29, 1'b0);
    check("post_rst_m",     64'(m_obs),    64'(17));
    check("post_rst_dones", 64'(done_cnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
